// File: rtl/mdu_sequencer_pkg.sv
// Shared types and op-decode helpers for the M-extension sequencer.
package mdu_sequencer_pkg;

    typedef enum logic [4:0] {
        AluAdd    = 5'd0,
        AluSub    = 5'd1,
        AluSll    = 5'd2,
        AluSlt    = 5'd3,
        AluSltu   = 5'd4,
        AluXor    = 5'd5,
        AluSrl    = 5'd6,
        AluSra    = 5'd7,
        AluOr     = 5'd8,
        AluAnd    = 5'd9,
        AluMul    = 5'd16,
        AluMulh   = 5'd17,
        AluMulhsu = 5'd18,
        AluMulhu  = 5'd19,
        AluDiv    = 5'd20,
        AluDivu   = 5'd21,
        AluRem    = 5'd22,
        AluRemu   = 5'd23
    } alu_operation_t;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } mdu_state_t;

    function automatic logic is_mdu_op(alu_operation_t op);
        return op inside {AluMul, AluMulh, AluMulhsu, AluMulhu,
                          AluDiv, AluDivu, AluRem, AluRemu};
    endfunction

    function automatic logic is_div_op(alu_operation_t op);
        return op inside {AluDiv, AluDivu, AluRem, AluRemu};
    endfunction

    function automatic logic is_rem_op(alu_operation_t op);
        return op inside {AluRem, AluRemu};
    endfunction

    function automatic logic is_signed_div(alu_operation_t op);
        return op inside {AluDiv, AluRem};
    endfunction

    // Operand signedness for the multiplier; MUL's low half is sign-agnostic.
    function automatic logic mul_a_signed(alu_operation_t op);
        return op != AluMulhu;
    endfunction

    function automatic logic mul_b_signed(alu_operation_t op);
        return op inside {AluMul, AluMulh};
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// EX-stage <-> multiply/divide unit handshake bundle.
interface mdu_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    import mdu_sequencer_pkg::*;

    logic             start_i;
    alu_operation_t   op_i;
    logic [XLEN-1:0]  a_i;
    logic [XLEN-1:0]  b_i;
    logic             flush_i;
    logic             ready_o;
    logic             busy_o;
    logic             valid_o;
    logic [XLEN-1:0]  result_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  ready_o, busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output ready_o, busy_o, valid_o, result_o
    );

endinterface

// File: rtl/mdu_div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module mdu_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          borrow;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, divisor_i};
        // rem < divisor keeps the true difference below 2^XLEN, so bit XLEN flags a borrow
        borrow  = diff[XLEN];
        rem_o   = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_o   = {quo_i[XLEN-2:0], ~borrow};
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle M-extension controller: registered multiplier plus iterative restoring divider.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    mdu_sequencer_if.slave    bus
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    alu_operation_t   op_q, op_d;
    logic [XLEN-1:0]  a_q, a_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic [XLEN-1:0]   step_rem;
    logic [XLEN-1:0]   step_quo;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] product;
    logic              accept;
    logic              a_neg;
    logic              b_neg;
    logic              div_by_zero;
    logic              overflow;

    mdu_div_step #(
        .XLEN(XLEN)
    ) u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (b_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        accept = (state_q == StIdle) && bus.start_i && is_mdu_op(bus.op_i) && !bus.flush_i;
        a_neg  = is_signed_div(bus.op_i) && bus.a_i[XLEN-1];
        b_neg  = is_signed_div(bus.op_i) && bus.b_i[XLEN-1];
        div_by_zero = (bus.b_i == '0);
        overflow    = is_signed_div(bus.op_i) && (bus.a_i == MinNeg) && (bus.b_i == '1);

        // Extending to 2*XLEN before an unsigned multiply gives the exact signed product.
        a_ext   = {{XLEN{mul_a_signed(op_q) & a_q[XLEN-1]}}, a_q};
        b_ext   = {{XLEN{mul_b_signed(op_q) & b_q[XLEN-1]}}, b_q};
        product = a_ext * b_ext;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d = bus.op_i;
                    if (!is_div_op(bus.op_i)) begin
                        a_d     = bus.a_i;
                        b_d     = bus.b_i;
                        state_d = StMul;
                    end else if (div_by_zero) begin
                        result_d = is_rem_op(bus.op_i) ? bus.a_i : '1;
                        state_d  = StDone;
                    end else if (overflow) begin
                        result_d = is_rem_op(bus.op_i) ? '0 : MinNeg;
                        state_d  = StDone;
                    end else begin
                        quo_d     = a_neg ? ('0 - bus.a_i) : bus.a_i;
                        b_d       = b_neg ? ('0 - bus.b_i) : bus.b_i;
                        rem_d     = '0;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = '0;
                        state_d   = StDiv;
                    end
                end
            end
            StMul: begin
                result_d = (op_q == AluMul) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
                state_d  = StDone;
            end
            StDiv: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(XLEN - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (is_rem_op(op_q)) begin
                    result_d = neg_rem_q ? ('0 - rem_q) : rem_q;
                end else begin
                    result_d = neg_quo_q ? ('0 - quo_q) : quo_q;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // An aborted op must leave the previously delivered result intact.
        if (bus.flush_i) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= AluAdd;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign bus.ready_o  = (state_q == StIdle);
    assign bus.busy_o   = (state_q != StIdle);
    assign bus.valid_o  = (state_q == StDone);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed and randomized checks of mdu_sequencer against a plain-arithmetic model.
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_exp = '0;

    mdu_sequencer_if #(.XLEN(32)) bus ();

    mdu_sequencer #(
        .XLEN(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(alu_operation_t op, logic [31:0] a, logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          p;
        longint unsigned pu;
        case (op)
            AluMul:    begin p = sa * sb; return p[31:0]; end
            AluMulh:   begin p = sa * sb; return p[63:32]; end
            AluMulhsu: begin p = sa * longint'(ub); return p[63:32]; end
            AluMulhu:  begin pu = ua * ub; return pu[63:32]; end
            AluDiv:    begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
            AluRem:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            AluDivu:   begin if (b == 0) return '1; pu = ua / ub; return pu[31:0]; end
            AluRemu:   begin if (b == 0) return a; pu = ua % ub; return pu[31:0]; end
            default:   return '0;
        endcase
    endfunction

    function automatic int ref_latency(alu_operation_t op, logic [31:0] a, logic [31:0] b);
        if (op inside {AluMul, AluMulh, AluMulhsu, AluMulhu}) return 2;
        if (b == 0) return 1;
        if ((op == AluDiv || op == AluRem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string tag, input alu_operation_t op,
                          input logic [31:0] a, input logic [31:0] b);
        int   n = 0;
        logic got = 1'b0;
        logic busy_bad = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.op_i    = alu_operation_t'(5'($urandom));
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
        while (n < 100 && !got) begin
            n++;
            @(negedge clk);
            if (bus.valid_o) got = 1'b1;
            if (!bus.busy_o || bus.ready_o) busy_bad = 1'b1;
        end
        check({tag, "_lat"}, 32'(n), 32'(ref_latency(op, a, b)));
        check({tag, "_res"}, bus.result_o, ref_result(op, a, b));
        check({tag, "_busy"}, {31'd0, busy_bad}, 32'd0);
        @(negedge clk);
        check({tag, "_pulse"}, {30'd0, bus.valid_o, bus.ready_o}, 32'd1);
        last_exp = ref_result(op, a, b);
    endtask

    task automatic count_valid(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.valid_o) pulses++;
        end
        check(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.op_i    = AluAdd;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.flush_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
        check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        check("rst_result", bus.result_o, 32'd0);
        rst = 1'b0;

        run_op("mul_7x-3", AluMul, 32'd7, 32'hFFFF_FFFD);
        check("mul_7x-3_const", last_exp, 32'hFFFF_FFEB);
        run_op("mulh_min", AluMulh, 32'h8000_0000, 32'h8000_0000);
        run_op("mulhu_min", AluMulhu, 32'h8000_0000, 32'h8000_0000);
        run_op("mulhsu_m1", AluMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_-20_3", AluDiv, 32'hFFFF_FFEC, 32'd3);
        check("div_-20_3_const", last_exp, 32'hFFFF_FFFA);
        run_op("rem_-20_3", AluRem, 32'hFFFF_FFEC, 32'd3);
        run_op("divu_100_7", AluDivu, 32'd100, 32'd7);
        run_op("remu_100_7", AluRemu, 32'd100, 32'd7);
        run_op("divu_by0", AluDivu, 32'd5, 32'd0);
        run_op("rem_by0", AluRem, 32'd5, 32'd0);
        run_op("div_ovf", AluDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", AluRem, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_20_-3", AluDiv, 32'd20, 32'hFFFF_FFFD);

        // Flush a divide mid-flight: no pulse, result untouched.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = AluDiv;
        bus.a_i     = 32'hFFFF_FFEC;
        bus.b_i     = 32'd3;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        @(negedge clk);
        check("flush_ready", {31'd0, bus.ready_o}, 32'd1);
        check("flush_result", bus.result_o, last_exp);
        count_valid("flush_novalid", 40);

        // Flush together with start wins.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = AluDivu;
        bus.a_i     = 32'd99;
        bus.b_i     = 32'd4;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check("startflush_ready", {31'd0, bus.ready_o}, 32'd1);
        count_valid("startflush_novalid", 40);

        // Non-M op is ignored.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = AluAdd;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        @(negedge clk);
        check("add_ignored", {31'd0, bus.ready_o}, 32'd1);
        count_valid("add_novalid", 5);

        // start held through DONE: second accept only after an IDLE cycle.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = AluMul;
        bus.a_i     = 32'd3;
        bus.b_i     = 32'd5;
        @(posedge clk);
        #1 bus.a_i = 32'd11;
        @(negedge clk);
        check("held_busy1", {31'd0, bus.busy_o}, 32'd1);
        @(negedge clk);
        check("held_done", {bus.valid_o, bus.ready_o, bus.result_o[29:0]},
              {1'b1, 1'b0, 30'd15});
        @(negedge clk);
        check("held_idle", {30'd0, bus.valid_o, bus.ready_o}, 32'd1);
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        @(negedge clk);
        check("held_busy2", {31'd0, bus.busy_o}, 32'd1);
        @(negedge clk);
        check("held_second", {bus.valid_o, bus.ready_o, bus.result_o[29:0]},
              {1'b1, 1'b0, 30'd55});

        // Reset in the middle of a divide.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = AluDiv;
        bus.a_i     = 32'd1000;
        bus.b_i     = 32'd7;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state", {29'd0, bus.ready_o, bus.busy_o, bus.valid_o}, 32'b100);
        check("midrst_result", bus.result_o, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            alu_operation_t rop;
            rop = alu_operation_t'(5'd16 + 5'($urandom_range(0, 7)));
            run_op($sformatf("rnd%0d", i), rop, pick_operand(), pick_operand());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
